li_counter_sched: RTL and testbench

Round-robin scheduler that shares one 32-bit gated event counter (registered count, wraps to 0 at MAX_COUNT, active-high clear) between two requesters.
Each requester asks for a measurement window of N clk_in cycles. The scheduler clears the counter, gates event_in into the counter enable for exactly N cycles, captures the count, and returns it on a tagged valid/ready result channel.
Sits between software-facing register logic and the shared counter instance.

---
 rtl/li_counter_sched.sv | 194 +++++++++++++++++++
 tb/tb_li_counter_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/li_counter_sched.sv
// li_counter_sched: round-robin scheduler sharing one gated event counter between
// two requesters. Each granted requester gets a window of N clk_in cycles in which
// event_in drives the counter enable. The captured count and an overflow flag are
// returned on a tagged valid/ready result channel.
//
// Window timeline for len = N:
//   CLEAR      : cnt_clr high, window counter holds N
//   RUN x N    : event_in sampled into cnt_enable (counter sees it one cycle later)
//   SETTLE x 2 : drains enable flop + counter flop; count captured in the 2nd cycle
//   DONE       : result presented until res_ready
module li_counter_sched #(
    parameter int unsigned WIN_W     = 16,
    parameter int unsigned MAX_COUNT = 65536
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               event_in,
    input  logic [1:0]         req_valid,
    input  logic [2*WIN_W-1:0] req_len,
    output logic [1:0]         req_ready,
    output logic               cnt_clr,
    output logic               cnt_enable,
    input  logic [31:0]        cnt_value,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [31:0]        res_data,
    output logic               res_ovf,
    output logic               busy
);

    localparam logic [31:0] MaxCount = 32'(MAX_COUNT);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSettle,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               gnt_q, gnt_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               settle_q, settle_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         req_ready_q, req_ready_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               cnt_enable_q, cnt_enable_d;
    logic               res_valid_q, res_valid_d;
    logic               res_id_q, res_id_d;
    logic [31:0]        res_data_q, res_data_d;
    logic               res_ovf_q, res_ovf_d;

    logic               arb_gnt;
    logic [1:0]         arb_onehot;
    logic               accept;
    logic               max_hit;
    logic [WIN_W-1:0]   sel_len;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        arb_gnt = 1'b0;
        if (req_valid == 2'b11) begin
            arb_gnt = ~last_grant_q;
        end else begin
            arb_gnt = req_valid[1];
        end
        arb_onehot = arb_gnt ? 2'b10 : 2'b01;
        accept     = |(req_ready_q & req_valid);
        max_hit    = (cnt_value == MaxCount);
        sel_len    = gnt_q ? req_len[2*WIN_W-1:WIN_W] : req_len[WIN_W-1:0];
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        win_d        = win_q;
        settle_d     = settle_q;
        ovf_d        = ovf_q;
        req_ready_d  = 2'b00;
        cnt_enable_d = 1'b0;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Ready was offered last cycle and the requester still holds valid.
                    state_d      = StClear;
                    last_grant_d = gnt_q;
                    win_d        = sel_len;
                end else if ((req_ready_q == 2'b00) && (|req_valid)) begin
                    req_ready_d = arb_onehot;
                    gnt_d       = arb_gnt;
                end
            end
            StClear: begin
                ovf_d    = 1'b0;
                settle_d = 1'b0;
                state_d  = (win_q != '0) ? StRun : StSettle;
            end
            StRun: begin
                ovf_d        = ovf_q | max_hit;
                cnt_enable_d = event_in;
                win_d        = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                ovf_d    = ovf_q | max_hit;
                settle_d = ~settle_q;
                if (settle_q) begin
                    state_d     = StDone;
                    res_valid_d = 1'b1;
                    res_id_d    = gnt_q;
                    res_data_d  = cnt_value;
                    res_ovf_d   = ovf_q | max_hit;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so the counter's asynchronous clear can never glitch.
        cnt_clr_d = (state_d == StClear);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            win_q        <= '0;
            settle_q     <= 1'b0;
            ovf_q        <= 1'b0;
            req_ready_q  <= 2'b00;
            cnt_clr_q    <= 1'b0;
            cnt_enable_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            win_q        <= win_d;
            settle_q     <= settle_d;
            ovf_q        <= ovf_d;
            req_ready_q  <= req_ready_d;
            cnt_clr_q    <= cnt_clr_d;
            cnt_enable_q <= cnt_enable_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

    // Output decode.
    always_comb begin
        req_ready  = req_ready_q;
        cnt_clr    = cnt_clr_q;
        cnt_enable = cnt_enable_q;
        res_valid  = res_valid_q;
        res_id     = res_id_q;
        res_data   = res_data_q;
        res_ovf    = res_ovf_q;
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_li_counter_sched.sv
// Directed bench for li_counter_sched with a behavioural shared counter.
module tb_li_counter_sched;

    localparam int unsigned WIN_W = 16;
    localparam int unsigned MAXC  = 16;

    logic               clk_in = 1'b0;
    logic               reset_n = 1'b0;
    logic               event_in;
    logic [1:0]         req_valid = 2'b00;
    logic [2*WIN_W-1:0] req_len = '0;
    logic [1:0]         req_ready;
    logic               cnt_clr;
    logic               cnt_enable;
    logic [31:0]        cnt_value = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               res_id;
    logic [31:0]        res_data;
    logic               res_ovf;
    logic               busy;

    logic [1:0]         ev_mode = 2'd0;  // 0: low, 1: high, 2: toggle aligned to window
    logic               ev_tog = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    li_counter_sched #(
        .WIN_W     (WIN_W),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .event_in   (event_in),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .cnt_clr    (cnt_clr),
        .cnt_enable (cnt_enable),
        .cnt_value  (cnt_value),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    // Shared counter: async clear, counts up to MAXC then wraps to 0.
    always @(posedge clk_in or posedge cnt_clr) begin
        if (cnt_clr) cnt_value <= '0;
        else if (cnt_enable) cnt_value <= (cnt_value == MAXC) ? 32'd0 : cnt_value + 32'd1;
    end

    // Toggle pattern restarts at 1 in the first RUN cycle of every window.
    always @(posedge clk_in) ev_tog <= cnt_clr ? 1'b1 : ~ev_tog;
    assign event_in = (ev_mode == 2'd2) ? ev_tog : ev_mode[0];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b0;
        ev_mode   = 2'd0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Runs until res_valid (bounded); optionally drops valid of an accepted requester.
    task automatic run_window(input bit auto_drop, output int n_rdy, output logic [1:0] rdy_seen,
                              output int n_clr, output int n_en, output int n_both,
                              output bit to);
        logic [1:0] drop;
        drop     = 2'b00;
        n_rdy    = 0;
        rdy_seen = 2'b00;
        n_clr    = 0;
        n_en     = 0;
        n_both   = 0;
        to       = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            req_valid = req_valid & ~drop;
            drop      = 2'b00;
            if (req_ready != 2'b00) begin
                n_rdy++;
                rdy_seen = req_ready;
                if (auto_drop) drop = req_ready;
            end
            if (cnt_clr) n_clr++;
            if (cnt_enable) n_en++;
            if (cnt_clr && cnt_enable) n_both++;
            if (res_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int         n_rdy, n_clr, n_en, n_both, bad;
        logic [1:0] rdy_seen;
        bit         to;

        // Reset state
        do_reset();
        check("rst_ctl", 32'({req_ready, cnt_clr, cnt_enable, res_valid, res_id, res_ovf, busy}), 0);
        check("rst_data", res_data, 0);

        // Single window, len 10, events every cycle
        req_len   = {16'd0, 16'd10};
        ev_mode   = 2'd1;
        req_valid = 2'b01;
        run_window(1'b1, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("w1_timeout", 32'(to), 0);
        check("w1_rdy", 32'(rdy_seen), 1);
        check("w1_rdy_cycles", 32'(n_rdy), 1);
        check("w1_clr_cycles", 32'(n_clr), 1);
        check("w1_en_cycles", 32'(n_en), 10);
        check("w1_clr_en_overlap", 32'(n_both), 0);
        check("w1_id", 32'(res_id), 0);
        check("w1_data", res_data, 10);
        check("w1_ovf", 32'(res_ovf), 0);
        res_ready = 1'b1;
        tick();
        check("w1_valid_drop", 32'({res_valid, busy}), 0);
        res_ready = 1'b0;

        // Round robin with both requesters held, toggling events -> 2 per window
        do_reset();
        req_len   = {16'd4, 16'd4};
        ev_mode   = 2'd2;
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_window(1'b0, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
            check("rr_timeout", 32'(to), 0);
            check("rr_gnt", 32'(rdy_seen), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_id", 32'(res_id), 32'(k % 2));
            check("rr_data", res_data, 2);
        end

        // Zero-length window on requester 1
        do_reset();
        req_len   = {16'd0, 16'd9};
        ev_mode   = 2'd1;
        req_valid = 2'b10;
        run_window(1'b1, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("z_timeout", 32'(to), 0);
        check("z_rdy", 32'(rdy_seen), 2);
        check("z_en_cycles", 32'(n_en), 0);
        check("z_id", 32'(res_id), 1);
        check("z_data", res_data, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Backpressure: result held 20 cycles, no grants meanwhile
        do_reset();
        req_len   = {16'd6, 16'd3};
        ev_mode   = 2'd1;
        req_valid = 2'b11;
        run_window(1'b0, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("bp_timeout", 32'(to), 0);
        check("bp_rdy", 32'(rdy_seen), 1);
        check("bp_data", res_data, 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!res_valid || res_data != 32'd3 || req_ready != 2'b00) bad++;
        end
        check("bp_hold", 32'(bad), 0);
        res_ready = 1'b1;
        tick();
        check("bp_idle_gap", 32'({req_ready, res_valid, busy}), 0);
        res_ready = 1'b0;
        tick();
        check("bp_next_gnt", 32'(req_ready), 2);
        run_window(1'b0, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("bp2_timeout", 32'(to), 0);
        check("bp2_id", 32'(res_id), 1);
        check("bp2_data", res_data, 6);

        // Counter wrap at MAXC=16 with len 20
        do_reset();
        req_len   = {16'd0, 16'd20};
        ev_mode   = 2'd1;
        req_valid = 2'b01;
        run_window(1'b1, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("ovf_timeout", 32'(to), 0);
        check("ovf_flag", 32'(res_ovf), 1);
        check("ovf_data", res_data, 3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset mid-RUN, then requester 0 wins again
        do_reset();
        req_len   = {16'd0, 16'd10};
        ev_mode   = 2'd1;
        req_valid = 2'b01;
        bad = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cnt_enable) begin
                bad = 0;
                break;
            end
        end
        check("mr_run_seen", 32'(bad), 0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_async_ctl",
              32'({req_ready, cnt_clr, cnt_enable, res_valid, res_id, res_ovf, busy}), 0);
        check("mr_async_data", res_data, 0);
        req_valid = 2'b11;
        req_len   = {16'd7, 16'd5};
        tick();
        tick();
        reset_n = 1'b1;
        run_window(1'b1, n_rdy, rdy_seen, n_clr, n_en, n_both, to);
        check("mr_timeout", 32'(to), 0);
        check("mr_rdy", 32'(rdy_seen), 1);
        check("mr_id", 32'(res_id), 0);
        check("mr_data", res_data, 5);
        check("mr_ovf", 32'(res_ovf), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
